// File: rtl/qr_mgs_sequencer.sv
// qr_mgs_sequencer
// ----------------
// Control sequencer for a Modified Gram-Schmidt QR decomposition of an
// N-column matrix. It walks the pivot column i and the target columns j > i,
// issuing load / normalise / dot / scale / subtract requests to external
// datapath units and waiting for each unit's done pulse.
//
// Handshake: each *_req is a level that is high for every cycle the FSM sits
// in the matching state. The paired *_done is sampled on the rising edge while
// the req is high. A done seen at that edge moves the FSM on, and the req is
// low from the next cycle. A done that arrives in the same cycle the req first
// rises is accepted. A done that arrives while its state is not active is
// ignored.
//
// Ports
//   clk, reset_n        clock, synchronous active-low reset
//   start               begin a decomposition (sampled in IDLE only)
//   abort               cancel a run in progress (ignored in IDLE)
//   load_done .. sub_done   completion pulses from the datapath units
//   load_req .. sub_req     request levels to the datapath units
//   col_i, col_j        pivot / target column indices
//   src_input           operand column comes from the input buffer (pivot 0)
//   busy                FSM is not in IDLE
//   done                one-cycle pulse on normal completion
//   err                 sticky timeout flag, cleared by start or reset
//   dbg_state           current FSM state, for debug and checkers
module qr_mgs_sequencer #(
  parameter int N   = 4,
  parameter int CW  = $clog2(N) + 1,
  parameter int TMO = 1023
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic          load_done,
  input  logic          norm_done,
  input  logic          dot_done,
  input  logic          mul_done,
  input  logic          sub_done,
  output logic          load_req,
  output logic          norm_req,
  output logic          dot_req,
  output logic          mul_req,
  output logic          sub_req,
  output logic [CW-1:0] col_i,
  output logic [CW-1:0] col_j,
  output logic          src_input,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [3:0]    dbg_state
);

  localparam int TW = (TMO < 2) ? 1 : $clog2(TMO + 1);

  typedef enum logic [3:0] {
    IDLE, LOAD, NORM, NEXT_J, DOT, MUL, SUB, NEXT_I, FIN
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] col_i_q, col_i_d;
  logic [CW-1:0] col_j_q, col_j_d;
  logic [CW-1:0] col_i_inc;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          req_act;
  logic          done_in;
  logic          tmo_hit;

  always_comb begin
    req_act   = (state_q == LOAD) || (state_q == NORM) || (state_q == DOT) ||
                (state_q == MUL)  || (state_q == SUB);
    col_i_inc = col_i_q + CW'(1);

    unique case (state_q)
      LOAD:    done_in = load_done;
      NORM:    done_in = norm_done;
      DOT:     done_in = dot_done;
      MUL:     done_in = mul_done;
      SUB:     done_in = sub_done;
      default: done_in = 1'b0;
    endcase

    // The counter holds the number of req cycles already spent in this state,
    // so the req stays high for exactly TMO cycles before the run is dropped.
    // A done in that last cycle still wins.
    tmo_hit = (TMO != 0) && req_act && !done_in && (tmo_q == TW'(TMO - 1));

    state_d = state_q;
    col_i_d = col_i_q;
    col_j_d = col_j_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (load_done) begin
          state_d = NORM;
          col_i_d = '0;
        end
      end
      NORM: begin
        if (norm_done) begin
          state_d = NEXT_J;
          col_j_d = col_i_inc;
        end
      end
      NEXT_J:  state_d = (col_j_q < CW'(N)) ? DOT : NEXT_I;
      DOT:     if (dot_done) state_d = MUL;
      MUL:     if (mul_done) state_d = SUB;
      SUB: begin
        if (sub_done) begin
          state_d = NEXT_J;
          col_j_d = col_j_q + CW'(1);
        end
      end
      NEXT_I: begin
        col_i_d = col_i_inc;
        state_d = (col_i_inc < CW'(N)) ? NORM : FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (tmo_hit) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end

    // Abort overrides any coincident done, so the indices are restored too.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      col_i_d = col_i_q;
      col_j_d = col_j_q;
      err_d   = err_q;
    end

    if (state_d != state_q) begin
      tmo_d = '0;
    end else if (req_act) begin
      tmo_d = tmo_q + TW'(1);
    end else begin
      tmo_d = tmo_q;
    end
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they describe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      col_i_q   <= '0;
      col_j_q   <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      load_req  <= 1'b0;
      norm_req  <= 1'b0;
      dot_req   <= 1'b0;
      mul_req   <= 1'b0;
      sub_req   <= 1'b0;
      src_input <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_i_q   <= col_i_d;
      col_j_q   <= col_j_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      load_req  <= (state_d == LOAD);
      norm_req  <= (state_d == NORM);
      dot_req   <= (state_d == DOT);
      mul_req   <= (state_d == MUL);
      sub_req   <= (state_d == SUB);
      src_input <= (col_i_d == '0) &&
                   ((state_d == NORM) || (state_d == DOT) ||
                    (state_d == MUL)  || (state_d == SUB));
      busy      <= (state_d != IDLE);
      done      <= (state_d == FIN);
    end
  end

  assign col_i     = col_i_q;
  assign col_j     = col_j_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_qr_mgs_sequencer.sv
// Testbench for qr_mgs_sequencer.
// Instance A: N=3, TMO=8, driven by a responder that returns each done one
// cycle after its req rises. Instance B: N=2, driven from a per-cycle vector
// table with zero-latency dones.
module tb_qr_mgs_sequencer;

  localparam int NA  = 3;
  localparam int TA  = 8;
  localparam int CWA = $clog2(NA) + 1;
  localparam int NB  = 2;
  localparam int CWB = $clog2(NB) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT A ----------------
  logic           a_rst_n, a_start, a_abort;
  logic           a_ld, a_nd, a_dd, a_md, a_sd;
  logic           a_lr, a_nr, a_dr, a_mr, a_sr;
  logic [CWA-1:0] a_ci, a_cj;
  logic           a_src, a_busy, a_done, a_err;
  logic [3:0]     a_dbg;
  wire  [4:0]     a_req = {a_lr, a_nr, a_dr, a_mr, a_sr};

  qr_mgs_sequencer #(.N(NA), .TMO(TA)) u_dut_a (
    .clk(clk), .reset_n(a_rst_n), .start(a_start), .abort(a_abort),
    .load_done(a_ld), .norm_done(a_nd), .dot_done(a_dd), .mul_done(a_md),
    .sub_done(a_sd),
    .load_req(a_lr), .norm_req(a_nr), .dot_req(a_dr), .mul_req(a_mr),
    .sub_req(a_sr), .col_i(a_ci), .col_j(a_cj), .src_input(a_src),
    .busy(a_busy), .done(a_done), .err(a_err), .dbg_state(a_dbg)
  );

  // ---------------- DUT B ----------------
  logic           b_rst_n, b_start, b_abort;
  logic           b_ld, b_nd, b_dd, b_md, b_sd;
  logic           b_lr, b_nr, b_dr, b_mr, b_sr;
  logic [CWB-1:0] b_ci, b_cj;
  logic           b_src, b_busy, b_done, b_err;
  logic [3:0]     b_dbg;

  qr_mgs_sequencer #(.N(NB)) u_dut_b (
    .clk(clk), .reset_n(b_rst_n), .start(b_start), .abort(b_abort),
    .load_done(b_ld), .norm_done(b_nd), .dot_done(b_dd), .mul_done(b_md),
    .sub_done(b_sd),
    .load_req(b_lr), .norm_req(b_nr), .dot_req(b_dr), .mul_req(b_mr),
    .sub_req(b_sr), .col_i(b_ci), .col_j(b_cj), .src_input(b_src),
    .busy(b_busy), .done(b_done), .err(b_err), .dbg_state(b_dbg)
  );

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [11:0] exp_q[$];
  logic [4:0]  prev_req;
  logic        hold_dot;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Event code: kind (1 norm, 2 dot, 3 mul, 4 sub, 5 done), i, j, src.
  function automatic logic [11:0] ev(input int kind, input int i, input int j,
                                     input logic s);
    logic [11:0] v;
    v = {kind[2:0], i[3:0], j[3:0], s};
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_a_dones();
    {a_ld, a_nd, a_dd, a_md, a_sd} = 5'b0;
  endtask

  // Latency-1 responder: a done goes high in the second cycle of its req.
  task automatic respond();
    logic [4:0] r;
    r = a_req;
    {a_ld, a_nd, a_dd, a_md, a_sd} = r & prev_req;
    if (hold_dot) a_dd = 1'b0;
    prev_req = r;
  endtask

  // Full N=3 run with the responder, checked against an event scoreboard.
  task automatic run_full(input string tag);
    logic [4:0]  r, rising;
    logic [11:0] obs;
    int          req_cycles;
    int          done_cnt;
    bit          fin;
    exp_q.delete();
    for (int i = 0; i < NA; i++) begin
      exp_q.push_back(ev(1, i, 0, i == 0));
      for (int j = i + 1; j < NA; j++) begin
        exp_q.push_back(ev(2, i, j, i == 0));
        exp_q.push_back(ev(3, i, j, i == 0));
        exp_q.push_back(ev(4, i, j, i == 0));
      end
    end
    exp_q.push_back(ev(5, 0, 0, 1'b0));
    prev_req   = '0;
    req_cycles = 0;
    done_cnt   = 0;
    fin        = 0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int c = 0; c < 300 && !fin; c++) begin
      r          = a_req;
      rising     = r & ~prev_req;
      req_cycles += $countones(r);
      for (int k = 1; k <= 4; k++) begin
        if (rising[4-k]) begin
          obs = ev(k, int'(a_ci), (k == 1) ? 0 : int'(a_cj), a_src);
          if (exp_q.size() == 0) check({tag, " extra event"}, obs, 12'h0);
          else check({tag, " event"}, obs, exp_q.pop_front());
        end
      end
      if (a_done) begin
        done_cnt++;
        check({tag, " done event"}, ev(5, 0, 0, 1'b0), exp_q.pop_front());
        respond();
        tick();
        check({tag, " busy/done after done"}, {a_busy, a_done}, 2'b00);
        fin = 1;
      end else begin
        respond();
        tick();
      end
    end
    clear_a_dones();
    check({tag, " events left"}, exp_q.size(), 0);
    check({tag, " done count"}, done_cnt, 1);
    check({tag, " req cycles"}, req_cycles, 26);
  endtask

  // ---------------- vector table for instance B ----------------
  typedef struct {
    logic [5:0] in;    // start, load_done, norm_done, dot_done, mul_done, sub_done
    logic [4:0] req;   // load, norm, dot, mul, sub
    int         ci;
    int         cj;
    logic       src;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vt[14];

  initial begin
    logic [15:0] act_v, exp_v;
    int          cnt;
    bit          hit;
    bit          seen_done;

    vt[0]  = '{6'b100000, 5'b00000, 0, 0, 1'b0, 1'b0, 1'b0};  // IDLE
    vt[1]  = '{6'b010100, 5'b10000, 0, 0, 1'b0, 1'b1, 1'b0};  // LOAD, stray dot_done
    vt[2]  = '{6'b001000, 5'b01000, 0, 0, 1'b1, 1'b1, 1'b0};  // NORM i=0
    vt[3]  = '{6'b000000, 5'b00000, 0, 1, 1'b0, 1'b1, 1'b0};  // NEXT_J
    vt[4]  = '{6'b100100, 5'b00100, 0, 1, 1'b1, 1'b1, 1'b0};  // DOT, stray start
    vt[5]  = '{6'b000010, 5'b00010, 0, 1, 1'b1, 1'b1, 1'b0};  // MUL
    vt[6]  = '{6'b000001, 5'b00001, 0, 1, 1'b1, 1'b1, 1'b0};  // SUB
    vt[7]  = '{6'b000000, 5'b00000, 0, 2, 1'b0, 1'b1, 1'b0};  // NEXT_J
    vt[8]  = '{6'b000000, 5'b00000, 0, 2, 1'b0, 1'b1, 1'b0};  // NEXT_I
    vt[9]  = '{6'b001000, 5'b01000, 1, 2, 1'b0, 1'b1, 1'b0};  // NORM i=1
    vt[10] = '{6'b000000, 5'b00000, 1, 2, 1'b0, 1'b1, 1'b0};  // NEXT_J
    vt[11] = '{6'b000000, 5'b00000, 1, 2, 1'b0, 1'b1, 1'b0};  // NEXT_I
    vt[12] = '{6'b000000, 5'b00000, 2, 2, 1'b0, 1'b1, 1'b1};  // FIN
    vt[13] = '{6'b000000, 5'b00000, 2, 2, 1'b0, 1'b0, 1'b0};  // IDLE

    a_rst_n = 1'b0; a_start = 1'b0; a_abort = 1'b0; clear_a_dones();
    b_rst_n = 1'b0; b_start = 1'b0; b_abort = 1'b0;
    {b_ld, b_nd, b_dd, b_md, b_sd} = 5'b0;
    prev_req = '0;
    hold_dot = 1'b0;
    tick();
    tick();
    check("A reset outputs", {a_req, 3'(a_ci), 3'(a_cj), a_src, a_busy, a_done, a_err}, 0);
    check("B reset outputs", {b_lr, b_nr, b_dr, b_mr, b_sr, 2'(b_ci), 2'(b_cj),
                              b_src, b_busy, b_done, b_err}, 0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    tick();

    // N=2 zero-latency table
    for (int r = 0; r < 14; r++) begin
      act_v = {b_lr, b_nr, b_dr, b_mr, b_sr, 4'(b_ci), 4'(b_cj), b_src, b_busy, b_done};
      exp_v = {vt[r].req, 4'(vt[r].ci), 4'(vt[r].cj), vt[r].src, vt[r].busy, vt[r].done};
      check($sformatf("N2 row %0d", r), act_v, exp_v);
      {b_start, b_ld, b_nd, b_dd, b_md, b_sd} = vt[r].in;
      tick();
    end
    {b_start, b_ld, b_nd, b_dd, b_md, b_sd} = 6'b0;

    // abort in IDLE is ignored; start+abort together starts a run
    a_abort = 1'b1;
    tick();
    check("abort in IDLE", {a_busy, a_lr}, 2'b00);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_abort = 1'b0;
    check("start+abort in IDLE", {a_busy, a_lr}, 2'b11);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    check("abort in LOAD", {a_busy, a_req}, 6'b0);

    // full N=3 run, latency-1 dones
    run_full("n3 run");

    // abort during MUL (0,2) with a coincident mul_done
    prev_req = '0;
    hit      = 0;
    a_start  = 1'b1;
    tick();
    a_start = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (a_mr && a_ci == 0 && a_cj == 2 && prev_req[1]) begin
        respond();
        a_abort = 1'b1;
        hit     = 1;
      end else begin
        respond();
      end
      tick();
    end
    a_abort = 1'b0;
    clear_a_dones();
    check("abort reached MUL(0,2)", hit, 1);
    check("abort outputs", {a_req, a_busy, a_done, a_err}, 8'b0);
    tick();
    check("abort stays idle", {a_req, a_busy, a_done}, 7'b0);
    run_full("rerun after abort");

    // timeout with dot_done withheld
    hold_dot  = 1'b1;
    prev_req  = '0;
    cnt       = 0;
    seen_done = 0;
    a_start   = 1'b1;
    tick();
    a_start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (a_done) seen_done = 1;
      if (a_dr) cnt++;
      else if (cnt > 0) break;
      respond();
      tick();
    end
    hold_dot = 1'b0;
    clear_a_dones();
    check("timeout dot_req cycles", cnt, TA);
    check("timeout err/busy/done", {a_err, a_busy, a_done, seen_done}, 4'b1000);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("start clears err", {a_err, a_lr}, 2'b01);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    check("abort keeps err clear", {a_err, a_busy}, 2'b00);

    // reset during NORM i=1
    prev_req = '0;
    hit      = 0;
    a_start  = 1'b1;
    tick();
    a_start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (a_nr && a_ci == 1) begin
        hit = 1;
        break;
      end
      respond();
      tick();
    end
    clear_a_dones();
    check("reached NORM i=1", hit, 1);
    a_rst_n = 1'b0;
    a_nd    = 1'b1;
    tick();
    a_nd = 1'b0;
    check("mid-run reset outputs",
          {a_req, 3'(a_ci), 3'(a_cj), a_src, a_busy, a_done, a_err}, 0);
    a_rst_n = 1'b1;
    a_start = 1'b1;
    tick();
    check("first start after reset", {a_busy, a_lr}, 2'b11);
    tick();
    tick();
    a_start = 1'b0;
    check("start ignored while busy", {a_busy, a_req}, 6'b110000);
    a_ld = 1'b1;
    tick();
    a_ld = 1'b0;
    check("NORM i=0 after load", {a_nr, 3'(a_ci), a_src}, 5'b1_000_1);
    a_abort = 1'b1;
    a_nd    = 1'b1;
    tick();
    a_abort = 1'b0;
    a_nd    = 1'b0;
    check("abort beats norm_done", {a_req, a_busy, a_done, 3'(a_cj)}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qr_mgs_sequencer.md
QR_MGS_SEQUENCER -- requirements
Module: qr_mgs_sequencer

Interface
REQ-001 The module SHALL have parameter N, default 4, giving the matrix column count; the legal range is 2..16.
REQ-002 The module SHALL have parameter CW, default $clog2(N)+1, giving the column-index width.
REQ-003 The module SHALL have parameter TMO, default 1023, giving the maximum number of cycles any request may wait for its done; 0 disables the check.
REQ-004 The module SHALL have the following ports, one per line:
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  begin one decomposition; sampled in IDLE only.
- abort  in  1  synchronous cancel of a run in progress.
- load_done  in  1  input matrix loaded into the buffer; one-cycle pulse.
- norm_done  in  1  normalisation of column i complete; pulse.
- dot_done  in  1  dot product q_i·a_j complete; pulse.
- mul_done  in  1  scaling r_ij·q_i complete; pulse.
- sub_done  in  1  a_j update complete; pulse.
- load_req  out  1  request to load the input matrix.
- norm_req  out  1  request to normalise column i.
- dot_req  out  1  request for the dot product.
- mul_req  out  1  request for the scaling.
- sub_req  out  1  request for the subtraction.
- col_i  out  CW  current outer (pivot) column.
- col_j  out  CW  current inner (target) column.
- src_input  out  1  operand column is read from the input buffer (1) or the modified buffer (0).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  sticky timeout flag; cleared by start or reset.

Function
REQ-005 The FSM SHALL use exactly these states: IDLE, LOAD, NORM, NEXT_J, DOT, MUL, SUB, NEXT_I, FIN.
REQ-006 The FSM SHALL take the following transitions:
- IDLE -> LOAD on start.
- LOAD -> NORM on load_done, with col_i=0.
- NORM -> NEXT_J on norm_done, with col_j=col_i+1.
- NEXT_J -> DOT if col_j<N, else -> NEXT_I.
- DOT -> MUL on dot_done.
- MUL -> SUB on mul_done.
- SUB -> NEXT_J on sub_done, with col_j incremented.
- NEXT_I: col_i is incremented; the FSM goes to NORM if the new col_i<N, else to FIN.
- FIN -> IDLE unconditionally, with a done pulse in FIN.
REQ-007 Each *_req SHALL be a level held high for every cycle the FSM is in the matching state (load_req in LOAD, norm_req in NORM, dot_req in DOT, mul_req in MUL, sub_req in SUB), and low otherwise.
REQ-008 A done input arriving while its state is not active SHALL be ignored.
REQ-009 The req SHALL deassert in the cycle after its done is sampled.
REQ-010 A done asserted in the same cycle the req first rises SHALL be accepted, giving a minimum state residency of 1 cycle.
REQ-011 col_i and col_j SHALL change only on the transitions listed in REQ-006 and SHALL stay stable while any req is high.
REQ-012 src_input SHALL be 1 in NORM when col_i==0, and in DOT/MUL/SUB when col_i==0; it SHALL be 0 in all other states and cases.
REQ-013 NEXT_J and NEXT_I SHALL each last exactly 1 cycle.
REQ-014 The last column (col_i=N-1) SHALL perform NORM only, with no DOT/MUL/SUB.
REQ-015 The total count of NORM entries SHALL be N, and of DOT entries N(N-1)/2.
REQ-016 A timeout counter SHALL reset on every state entry and count while a req is high.
REQ-017 When the counter reaches TMO, err SHALL be set and the FSM SHALL go to IDLE with no done pulse.
REQ-018 abort in any non-IDLE state SHALL force IDLE on the next edge, drop all reqs, leave err unchanged and give no done.
REQ-019 abort SHALL have priority over a coincident done.
REQ-020 abort in IDLE SHALL be ignored.
REQ-021 start while busy SHALL be ignored.
REQ-022 start and abort asserted together in IDLE SHALL start a run.
REQ-023 Index arithmetic SHALL use CW bits; with CW ≥ clog2(N)+1, the value N is representable and no wrap occurs.

Reset
REQ-024 When reset_n is low at a rising edge, the FSM SHALL enter IDLE and all outputs SHALL be 0: reqs, col_i, col_j, src_input, busy, done, err.
REQ-025 Reset asserted mid-run SHALL override every other input and cancel the run without a done pulse.
REQ-026 The first start SHALL be accepted on the first edge after reset_n goes high.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- N=3, every done returned 1 cycle after its req -> norm_req visits (i)=0,1,2; dot_req visits (i,j)=(0,1),(0,2),(1,2); one done pulse; busy falls the cycle after done.
- N=3 -> src_input=1 for NORM i=0 and for dot/mul/sub at (0,1),(0,2); src_input=0 for NORM i=1,2 and at (1,2).
- Abort during MUL at (0,2) with a coincident mul_done -> IDLE next cycle, no SUB, done=0, err=0; a following start runs the full sequence.
- TMO=8, dot_done withheld -> err=1 after 8 req cycles, FSM in IDLE, done=0; the next start clears err.
- Reset_n low during NORM at i=1 -> all outputs 0 next cycle; start pulses before load_done are ignored while busy.
- N=2 with zero-latency done (done high the same cycle as req) -> NORM, DOT, MUL, SUB, NORM each 1 cycle; done pulses exactly once.
